// File: rtl/twiddle_fetch32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_fetch32_pkg
//  Description : Shared constants for the fft32 twiddle fetch path. Holds the
//                lane word width, the ROM word count, the ROM latency and hold
//                timing, and the fetch FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package twiddle_fetch32_pkg;

  // Lane word width: sign, exponent, mantissa. Mirrors `FFTsfpw in parameter.vh.
  localparam int FFT_SFPW    = 9;

  // ROM geometry: 8 words of 4 lanes each make up the 32 twiddles.
  localparam int TW_NWORD    = 8;
  localparam int TW_LANES    = 4;
  localparam int TW_AW       = $clog2(TW_NWORD);

  // ROM timing seen from the START cycle.
  localparam int TW_LAT      = 3;
  localparam int TW_HOLD     = 4;
  localparam int TW_SAMP_OFS = 2;

  // Fetch FSM state encodings.
  typedef logic [2:0] tw_state_t;
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_KICK  = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_CAP   = 3'd3;
  localparam logic [2:0] c_ST_SERVE = 3'd4;

endpackage : twiddle_fetch32_pkg
`default_nettype wire

// File: rtl/twiddle_cache8.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_cache8
//  Description : 8-entry register file holding one fetched twiddle set. Each
//                entry is {imag word, real word}. One synchronous write port,
//                one combinational read port. Contents are not reset; the
//                owner tracks validity.
//  Ports       : CLK    in   clock, rising edge
//                we     in   write enable
//                waddr  in   write address (0..7)
//                wdata  in   write data {imag, real}
//                raddr  in   read address (0..7)
//                rdata  out  read data, combinational from raddr
//  Revision    : 1.0  initial release
// ============================================================================
module twiddle_cache8
  import twiddle_fetch32_pkg::*;
#(
  parameter int WIDTH = 2 * FFT_SFPW * TW_LANES
) (
  input  logic                CLK,
  input  logic                we,
  input  logic [TW_AW-1:0]    waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [TW_AW-1:0]    raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] r_mem [TW_NWORD];

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : twiddle_cache8
`default_nettype wire

// File: rtl/twiddle_fetch32.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_fetch32
//  Description : Consumer side of the 32-point twiddle ROM. On LOAD it kicks
//                the ROM with the requested stage, samples the 8 four-lane
//                words into a local cache, then serves them to the butterfly
//                datapath as a valid/ready stream, words 0..7 repeating until
//                the next LOAD.
//  Ports       : CLK         in   clock, rising edge
//                RST         in   asynchronous reset, active low
//                LOAD        in   one-cycle (re)fetch request
//                LOAD_STAGE  in   stage to fetch (0 full set, 1 decimated)
//                START       out  one-cycle kick to the ROM
//                STAGE       out  stage select to the ROM, held per fetch
//                TW_R, TW_I  in   ROM real/imag words, lane0 in the LSBs
//                BUSY        out  fetch in progress
//                LOADED      out  cache holds a complete set
//                O_VLD       out  stream valid
//                O_RDY       in   stream ready
//                O_R, O_I    out  cached twiddle word
//                O_IDX       out  index of the word on O_R/O_I
//                O_LAST      out  high with O_IDX == 7
//  Revision    : 1.0  initial release
// ============================================================================
module twiddle_fetch32 #(
  parameter int NB       = twiddle_fetch32_pkg::FFT_SFPW,
  parameter int TW_LAT   = twiddle_fetch32_pkg::TW_LAT,
  parameter int TW_HOLD  = twiddle_fetch32_pkg::TW_HOLD,
  // Sample point inside each hold window; must be below TW_HOLD.
  parameter int SAMP_OFS = twiddle_fetch32_pkg::TW_SAMP_OFS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOAD,
  input  logic                 LOAD_STAGE,
  output logic                 START,
  output logic                 STAGE,
  input  logic [NB*4-1:0]      TW_R,
  input  logic [NB*4-1:0]      TW_I,
  output logic                 BUSY,
  output logic                 LOADED,
  output logic                 O_VLD,
  input  logic                 O_RDY,
  output logic [NB*4-1:0]      O_R,
  output logic [NB*4-1:0]      O_I,
  output logic [2:0]           O_IDX,
  output logic                 O_LAST
);

  import twiddle_fetch32_pkg::*;

  localparam int         c_WW        = NB * 4;
  // Clocks spent in WAIT so that the first CAP cycle is the sample cycle of word 0.
  localparam int         c_WAIT_CYC  = TW_LAT - 1 + SAMP_OFS;
  localparam logic [7:0] c_WAIT_LAST = 8'(c_WAIT_CYC - 1);
  localparam logic [7:0] c_HOLD_LAST = 8'(TW_HOLD - 1);
  localparam logic [2:0] c_LAST_WORD = 3'(TW_NWORD - 1);

  tw_state_t         r_state;
  logic              r_stage;
  logic              r_loaded;
  logic              r_vld;
  logic [2:0]        r_idx;    // stream read pointer
  logic [2:0]        r_widx;   // capture write pointer
  logic [7:0]        r_cnt;    // WAIT length counter, then hold-window phase in CAP

  logic              w_we;
  logic              w_xfer;
  logic [2*c_WW-1:0] w_rdata;

  // In CAP, phase 0 of each hold window lines up with the sample offset.
  assign w_we   = (r_state == c_ST_CAP) && (r_cnt == 8'd0);
  assign w_xfer = r_vld && O_RDY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= c_ST_IDLE;
      r_stage  <= 1'b0;
      r_loaded <= 1'b0;
      r_vld    <= 1'b0;
      r_idx    <= 3'd0;
      r_widx   <= 3'd0;
      r_cnt    <= 8'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (LOAD) begin
            r_state <= c_ST_KICK;
            r_stage <= LOAD_STAGE;
          end
        end

        c_ST_KICK: begin
          r_cnt  <= 8'd0;
          r_widx <= 3'd0;
          if (c_WAIT_CYC == 0) begin
            r_state <= c_ST_CAP;
          end else begin
            r_state <= c_ST_WAIT;
          end
        end

        c_ST_WAIT: begin
          if (r_cnt == c_WAIT_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= c_ST_CAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        c_ST_CAP: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_cnt <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
          if (w_we) begin
            if (r_widx == c_LAST_WORD) begin
              r_state  <= c_ST_SERVE;
              r_loaded <= 1'b1;
              r_vld    <= 1'b1;
              r_idx    <= 3'd0;
            end else begin
              r_widx <= r_widx + 3'd1;
            end
          end
        end

        c_ST_SERVE: begin
          // A LOAD on the same edge as a transfer overrides the pointer
          // advance; the transfer itself has still happened on the bus.
          if (LOAD) begin
            r_state  <= c_ST_KICK;
            r_stage  <= LOAD_STAGE;
            r_vld    <= 1'b0;
            r_loaded <= 1'b0;
            r_idx    <= 3'd0;
          end else if (w_xfer) begin
            r_idx <= r_idx + 3'd1;
          end
        end

        default: begin
          r_state  <= c_ST_IDLE;
          r_vld    <= 1'b0;
          r_loaded <= 1'b0;
        end
      endcase
    end
  end

  twiddle_cache8 #(
    .WIDTH (2 * c_WW)
  ) u_cache (
    .CLK   (CLK),
    .we    (w_we),
    .waddr (r_widx),
    .wdata ({TW_I, TW_R}),
    .raddr (r_idx),
    .rdata (w_rdata)
  );

  assign START  = (r_state == c_ST_KICK);
  assign BUSY   = (r_state == c_ST_KICK) || (r_state == c_ST_WAIT) ||
                  (r_state == c_ST_CAP);
  assign STAGE  = r_stage;
  assign LOADED = r_loaded;
  assign O_VLD  = r_vld;
  assign O_IDX  = r_idx;
  assign O_LAST = r_vld && (r_idx == c_LAST_WORD);
  // Cache contents are undefined until a fetch completes, so the data
  // outputs are forced to zero whenever nothing is being offered.
  assign O_R    = r_vld ? w_rdata[c_WW-1:0]      : '0;
  assign O_I    = r_vld ? w_rdata[2*c_WW-1:c_WW] : '0;

endmodule : twiddle_fetch32
`default_nettype wire

// File: tb/tb_twiddle_fetch32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_fetch32
//  Description : Self-checking bench for twiddle_fetch32 with a behavioural
//                twiddle ROM and table-driven stream vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_twiddle_fetch32;

  localparam int NB = 9;
  localparam int WW = NB * 4;
  localparam logic [8:0] c_ONE = 9'b010000000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          LOAD = 1'b0;
  logic          LOAD_STAGE = 1'b0;
  logic          O_RDY = 1'b0;
  logic          START, STAGE, BUSY, LOADED, O_VLD, O_LAST;
  logic [WW-1:0] TW_R, TW_I, O_R, O_I;
  logic [2:0]    O_IDX;

  twiddle_fetch32 dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD       (LOAD),
    .LOAD_STAGE (LOAD_STAGE),
    .START      (START),
    .STAGE      (STAGE),
    .TW_R       (TW_R),
    .TW_I       (TW_I),
    .BUSY       (BUSY),
    .LOADED     (LOADED),
    .O_VLD      (O_VLD),
    .O_RDY      (O_RDY),
    .O_R        (O_R),
    .O_I        (O_I),
    .O_IDX      (O_IDX),
    .O_LAST     (O_LAST)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Bookkeeping sampled on the rising edge (pre-update values).
  int cyc = 0;
  int start_cnt = 0;
  int kick_cyc = -1000;
  int acc_cnt = 0;
  int acc_last = -1;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (START) begin
      start_cnt <= start_cnt + 1;
      kick_cyc  <= cyc;
    end
    if (O_VLD && O_RDY) begin
      acc_cnt  <= acc_cnt + 1;
      acc_last <= int'(O_IDX);
    end
  end

  // ---------------- behavioural twiddle ROM ----------------
  logic [8:0] wr [32];
  logic [8:0] wi [32];
  int         rom_t = 99;
  logic       rom_stage = 1'b0;

  function automatic logic [WW-1:0] rom_word(input logic re, input int a);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[NB*j +: NB] = re ? wr[4*a+j] : wi[4*a+j];
    end
    return w;
  endfunction

  // Stage 1 repeats ROM word 0 for slots 0..3 and word 4 for slots 4..7.
  function automatic int rom_addr(input logic st, input int k);
    if (st) return (k < 4) ? 0 : 4;
    return k;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rom_t <= 99;
    end else if (START) begin
      rom_t     <= 1;
      rom_stage <= STAGE;
    end else if (rom_t < 99) begin
      rom_t <= rom_t + 1;
    end
  end

  // Word k is on the bus for 4 clocks starting 3 clocks after START.
  always_comb begin
    int k;
    k    = 0;
    TW_R = 36'h5A5A5A5A5;
    TW_I = 36'hA5A5A5A5A;
    if (rom_t >= 3 && rom_t < 35) begin
      k    = (rom_t - 3) / 4;
      TW_R = rom_word(1'b1, rom_addr(rom_stage, k));
      TW_I = rom_word(1'b0, rom_addr(rom_stage, k));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 60 && !O_VLD; i++) tick();
    chk("vld_timeout", 72'(O_VLD), 72'(1));
  endtask

  typedef struct {
    logic rdy;
    int   idx;
    logic st;
  } vec_t;
  vec_t vt [32];

  task automatic run_rows(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      chk("row_vld",  72'(O_VLD), 72'(1));
      chk("row_idx",  72'(O_IDX), 72'(vt[i].idx));
      chk("row_last", 72'(O_LAST), 72'(vt[i].idx == 7));
      chk("row_r",    72'(O_R), 72'(rom_word(1'b1, rom_addr(vt[i].st, vt[i].idx))));
      chk("row_i",    72'(O_I), 72'(rom_word(1'b0, rom_addr(vt[i].st, vt[i].idx))));
      if (!vt[i].st && vt[i].idx == 1)
        chk("w1_wi4", 72'(O_I[8:0]), 72'(9'b101110010));
      O_RDY = vt[i].rdy;
      tick();
    end
  endtask

  int sv_acc;
  int sc;

  initial begin
    for (int i = 0; i < 32; i++) begin
      wr[i] = (i < 4) ? c_ONE : 9'((i * 37 + 5) % 512);
      wi[i] = (i == 4) ? 9'b101110010 : 9'((i * 53 + 11) % 512);
    end

    // Stage 0 with 5-clock backpressure at index 2 and a full wrap.
    vt[0]  = '{1'b1, 0, 1'b0};  vt[1]  = '{1'b1, 1, 1'b0};
    vt[2]  = '{1'b0, 2, 1'b0};  vt[3]  = '{1'b0, 2, 1'b0};
    vt[4]  = '{1'b0, 2, 1'b0};  vt[5]  = '{1'b0, 2, 1'b0};
    vt[6]  = '{1'b0, 2, 1'b0};  vt[7]  = '{1'b1, 2, 1'b0};
    vt[8]  = '{1'b1, 3, 1'b0};  vt[9]  = '{1'b1, 4, 1'b0};
    vt[10] = '{1'b1, 5, 1'b0};  vt[11] = '{1'b1, 6, 1'b0};
    vt[12] = '{1'b1, 7, 1'b0};  vt[13] = '{1'b1, 0, 1'b0};
    vt[14] = '{1'b0, 1, 1'b0};
    // Stage 1 full pass.
    for (int i = 0; i < 8; i++) vt[15+i] = '{1'b1, i, 1'b1};
    vt[23] = '{1'b0, 0, 1'b1};
    // Stage 0 full pass.
    for (int i = 0; i < 8; i++) vt[24+i] = '{1'b1, i, 1'b0};

    // ---- reset ----
    #2 RST = 1'b0;
    tick(); tick();
    chk("rst_start",  72'(START),  72'(0));
    chk("rst_stage",  72'(STAGE),  72'(0));
    chk("rst_busy",   72'(BUSY),   72'(0));
    chk("rst_loaded", 72'(LOADED), 72'(0));
    chk("rst_vld",    72'(O_VLD),  72'(0));
    chk("rst_r",      72'(O_R),    72'(0));
    chk("rst_i",      72'(O_I),    72'(0));
    chk("rst_idx",    72'(O_IDX),  72'(0));
    chk("rst_last",   72'(O_LAST), 72'(0));
    RST = 1'b1;
    tick();

    // ---- stage 0 fetch ----
    LOAD = 1'b1; LOAD_STAGE = 1'b0;
    tick();
    LOAD = 1'b0;
    chk("a_start", 72'(START), 72'(1));
    chk("a_busy",  72'(BUSY),  72'(1));
    chk("a_stage", 72'(STAGE), 72'(0));
    wait_vld();
    chk("a_lat",    72'(cyc - kick_cyc), 72'(34));
    chk("a_loaded", 72'(LOADED), 72'(1));
    chk("a_busy0",  72'(BUSY),   72'(0));
    chk("a_starts", 72'(start_cnt), 72'(1));
    chk("a_w0r",    72'(O_R), 72'({4{c_ONE}}));
    run_rows(0, 14);

    // ---- abort at index 5 with O_RDY low, refetch stage 1 ----
    O_RDY = 1'b1;
    for (int i = 0; i < 10 && O_IDX != 3'd5; i++) tick();
    chk("b_at5", 72'(O_IDX), 72'(5));
    O_RDY = 1'b0; LOAD = 1'b1; LOAD_STAGE = 1'b1;
    sv_acc = acc_cnt;
    tick();
    LOAD = 1'b0;
    chk("b_vld0",    72'(O_VLD),  72'(0));
    chk("b_loaded0", 72'(LOADED), 72'(0));
    chk("b_start",   72'(START),  72'(1));
    chk("b_stage",   72'(STAGE),  72'(1));
    chk("b_acclast", 72'(acc_last), 72'(4));
    chk("b_acccnt",  72'(acc_cnt),  72'(sv_acc));
    wait_vld();
    chk("b_lat",    72'(cyc - kick_cyc), 72'(34));
    chk("b_starts", 72'(start_cnt), 72'(2));
    chk("b_w0r",    72'(O_R), 72'({4{c_ONE}}));
    run_rows(15, 23);

    // ---- LOAD in the middle of CAP is ignored ----
    sc = start_cnt;
    LOAD = 1'b1; LOAD_STAGE = 1'b0;
    tick();
    LOAD = 1'b0;
    repeat (15) tick();
    chk("c_busy", 72'(BUSY), 72'(1));
    LOAD = 1'b1; LOAD_STAGE = 1'b1;
    tick();
    LOAD = 1'b0;
    wait_vld();
    chk("c_starts", 72'(start_cnt), 72'(sc + 1));
    chk("c_lat",    72'(cyc - kick_cyc), 72'(34));
    chk("c_stage",  72'(STAGE), 72'(0));
    run_rows(24, 31);

    // ---- reset at capture k=4, then a clean fetch ----
    O_RDY = 1'b0;
    LOAD = 1'b1; LOAD_STAGE = 1'b0;
    tick();
    LOAD = 1'b0;
    repeat (21) tick();
    chk("d_busy1", 72'(BUSY), 72'(1));
    RST = 1'b0;
    #1;
    chk("d_busy0",   72'(BUSY),   72'(0));
    chk("d_loaded0", 72'(LOADED), 72'(0));
    chk("d_vld0",    72'(O_VLD),  72'(0));
    chk("d_start0",  72'(START),  72'(0));
    tick();
    RST = 1'b1;
    tick();
    chk("d_loaded_after", 72'(LOADED), 72'(0));
    LOAD = 1'b1; LOAD_STAGE = 1'b0;
    tick();
    LOAD = 1'b0;
    chk("d_start", 72'(START), 72'(1));
    wait_vld();
    chk("d_lat", 72'(cyc - kick_cyc), 72'(34));
    run_rows(24, 31);

    // ---- reset during service drops the stream asynchronously ----
    chk("e_vld1", 72'(O_VLD), 72'(1));
    #2 RST = 1'b0;
    #1;
    chk("e_vld0",    72'(O_VLD),  72'(0));
    chk("e_loaded0", 72'(LOADED), 72'(0));
    chk("e_r0",      72'(O_R),    72'(0));
    chk("e_idx0",    72'(O_IDX),  72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_twiddle_fetch32
`default_nettype wire
